// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier with valid/ready on both sides.
// Operands are reduced to magnitudes on accept. The unsigned magnitude product
// is accumulated one multiplier bit per cycle, and the sign is applied when the
// last iteration completes.
// Optional feature macro: SEQ_MULT_EARLY_TERM_EN. When it is defined, BUSY ends
// as soon as the remaining multiplier bits are all zero. When it is undefined,
// the latency is always WIDTH cycles.
module seq_multiplier #(
   parameter int WIDTH  = 8,
   parameter int SIGNED = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   P,
   output logic                 out_valid,
   input  logic                 out_ready
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1. in_ready is 1 only in IDLE. out_valid is 1 only in DONE.
   // P stays stable until the out_valid/out_ready transfer. Reset overrides
   // both handshakes.

   localparam int             CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_neg;
   logic [2*WIDTH-1:0]   r_p;

   logic                 w_accept;
   logic                 w_last;
   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;
   logic [2*WIDTH-1:0]   w_add;
   logic [2*WIDTH-1:0]   w_acc_next;

   // Operand magnitudes. The most negative value maps to 2**(WIDTH-1) as unsigned.
   assign w_a_neg    = (SIGNED != 0) && A[WIDTH-1];
   assign w_b_neg    = (SIGNED != 0) && B[WIDTH-1];
   assign w_a_mag    = w_a_neg ? -A : A;
   assign w_b_mag    = w_b_neg ? -B : B;

   assign w_accept   = in_valid && (r_state == IDLE);
   assign w_add      = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_add;

`ifdef SEQ_MULT_EARLY_TERM_EN
   assign w_last     = (r_mplier[WIDTH-1:1] == '0) || (r_cnt == CNT_LAST);
`else
   assign w_last     = (r_cnt == CNT_LAST);
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_next = BUSY;
         end
         BUSY: begin
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Datapath: capture on accept, one shift-add per BUSY cycle, publish P on the last iteration
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_neg    <= 1'b0;
         r_p      <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
         r_mplier <= w_b_mag;
         r_acc    <= '0;
         r_neg    <= w_a_neg ^ w_b_neg;
      end else if (r_state == BUSY) begin
         r_cnt    <= r_cnt + CW'(1);
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_acc    <= w_acc_next;
         if (w_last) r_p <= r_neg ? -w_acc_next : w_acc_next;
      end
   end

   assign P = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: WIDTH=2 unsigned, WIDTH=8 unsigned and
// WIDTH=8 signed instances share one clock and reset.
// Expected latencies follow SEQ_MULT_EARLY_TERM_EN when it is defined.
module tb_seq_multiplier;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   // WIDTH=2 unsigned
   logic [1:0]  w2_a = '0, w2_b = '0;
   logic        w2_in_valid = 1'b0, w2_out_ready = 1'b0;
   logic        w2_in_ready, w2_out_valid;
   logic [3:0]  w2_p;
   // WIDTH=8 unsigned
   logic [7:0]  u8_a = '0, u8_b = '0;
   logic        u8_in_valid = 1'b0, u8_out_ready = 1'b0;
   logic        u8_in_ready, u8_out_valid;
   logic [15:0] u8_p;
   // WIDTH=8 signed
   logic [7:0]  s8_a = '0, s8_b = '0;
   logic        s8_in_valid = 1'b0, s8_out_ready = 1'b0;
   logic        s8_in_ready, s8_out_valid;
   logic [15:0] s8_p;

   seq_multiplier #(.WIDTH(2), .SIGNED(0)) u_w2 (
      .clk(clk), .rst(rst), .A(w2_a), .B(w2_b), .in_valid(w2_in_valid),
      .in_ready(w2_in_ready), .P(w2_p), .out_valid(w2_out_valid), .out_ready(w2_out_ready));
   seq_multiplier #(.WIDTH(8), .SIGNED(0)) u_u8 (
      .clk(clk), .rst(rst), .A(u8_a), .B(u8_b), .in_valid(u8_in_valid),
      .in_ready(u8_in_ready), .P(u8_p), .out_valid(u8_out_valid), .out_ready(u8_out_ready));
   seq_multiplier #(.WIDTH(8), .SIGNED(1)) u_s8 (
      .clk(clk), .rst(rst), .A(s8_a), .B(s8_b), .in_valid(s8_in_valid),
      .in_ready(s8_in_ready), .P(s8_p), .out_valid(s8_out_valid), .out_ready(s8_out_ready));

   // Clock
   always #5 clk = ~clk;

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Expected latency for a multiplier magnitude
   function automatic int lat_model(input int width, input int mag);
`ifdef SEQ_MULT_EARLY_TERM_EN
      int h;
      h = 0;
      for (int i = 0; i < 32; i++) if ((mag >> i) & 1) h = i + 1;
      return (h == 0) ? 1 : h;
`else
      return width + (mag & 0);
`endif
   endfunction

   function automatic logic rdy(input int sel);
      case (sel)
         0:       return w2_in_ready;
         1:       return u8_in_ready;
         default: return s8_in_ready;
      endcase
   endfunction

   function automatic logic vld(input int sel);
      case (sel)
         0:       return w2_out_valid;
         1:       return u8_out_valid;
         default: return s8_out_valid;
      endcase
   endfunction

   function automatic logic [15:0] prod(input int sel);
      case (sel)
         0:       return {12'b0, w2_p};
         1:       return u8_p;
         default: return s8_p;
      endcase
   endfunction

   task automatic set_in(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic v, input logic ordy);
      case (sel)
         0: begin w2_a = a[1:0]; w2_b = b[1:0]; w2_in_valid = v; w2_out_ready = ordy; end
         1: begin u8_a = a; u8_b = b; u8_in_valid = v; u8_out_ready = ordy; end
         default: begin s8_a = a; s8_b = b; s8_in_valid = v; s8_out_ready = ordy; end
      endcase
   endtask

   // Driver: one full request/response. Returns the latency in edges from accept to out_valid.
   task automatic drive_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                           output int lat, output logic [15:0] p, output bit ok);
      int n;
      ok  = 1'b1;
      lat = 0;
      p   = '0;
      @(negedge clk);
      set_in(sel, a, b, 1'b1, 1'b0);
      n = 0;
      while (!rdy(sel) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rdy(sel)) begin
         ok = 1'b0;
         set_in(sel, a, b, 1'b0, 1'b0);
         return;
      end
      @(posedge clk);
      #1 set_in(sel, a, b, 1'b0, 1'b0);
      while (lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (vld(sel)) break;
      end
      if (!vld(sel)) ok = 1'b0;
      p = prod(sel);
      set_in(sel, a, b, 1'b0, 1'b1);
      @(posedge clk);
      #1 set_in(sel, a, b, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if (rdy(s) !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d got %b want 1", s, rdy(s)); end
         checks++;
         if (vld(s) !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got %b want 0", s, vld(s)); end
         checks++;
         if (prod(s) !== 16'h0) begin errors++; $display("FAIL reset_p dut%0d got %h want 0000", s, prod(s)); end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_w2_all();
      int lat;
      logic [15:0] p;
      bit ok;
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            drive_op(0, 8'(a), 8'(b), lat, p, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL w2_timeout a=%0d b=%0d got no out_valid want out_valid", a, b); end
            checks++;
            if (p !== 16'(a * b)) begin errors++; $display("FAIL w2_product %0d*%0d got %0d want %0d", a, b, p, a * b); end
            checks++;
            if (lat != lat_model(2, b)) begin errors++; $display("FAIL w2_latency b=%0d got %0d want %0d", b, lat, lat_model(2, b)); end
         end
      end
   endtask

   task automatic test_u8();
      logic [7:0]  va[5] = '{8'd255, 8'd0, 8'd13, 8'd1, 8'd200};
      logic [7:0]  vb[5] = '{8'd255, 8'd0, 8'd11, 8'd255, 8'd3};
      logic [15:0] ve[5] = '{16'd65025, 16'd0, 16'd143, 16'd255, 16'd600};
      int lat;
      logic [15:0] p;
      bit ok;
      for (int i = 0; i < 5; i++) begin
         drive_op(1, va[i], vb[i], lat, p, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL u8_timeout vec%0d got no out_valid want out_valid", i); end
         checks++;
         if (p !== ve[i]) begin errors++; $display("FAIL u8_product vec%0d got %0d want %0d", i, p, ve[i]); end
         checks++;
         if (lat != lat_model(8, int'(vb[i]))) begin errors++; $display("FAIL u8_latency vec%0d got %0d want %0d", i, lat, lat_model(8, int'(vb[i]))); end
      end
   endtask

   task automatic test_s8();
      logic [7:0]  va[6] = '{8'hFD, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'hF9};
      logic [7:0]  vb[6] = '{8'h05, 8'h80, 8'h80, 8'hFF, 8'hFB, 8'hF7};
      logic [15:0] ve[6] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0001, 16'h0000, 16'h003F};
      logic [7:0]  mag;
      int lat;
      logic [15:0] p;
      bit ok;
      for (int i = 0; i < 6; i++) begin
         mag = vb[i][7] ? 8'(-vb[i]) : vb[i];
         drive_op(2, va[i], vb[i], lat, p, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL s8_timeout vec%0d got no out_valid want out_valid", i); end
         checks++;
         if (p !== ve[i]) begin errors++; $display("FAIL s8_product vec%0d got %h want %h", i, p, ve[i]); end
         checks++;
         if (lat != lat_model(8, int'(mag))) begin errors++; $display("FAIL s8_latency vec%0d got %0d want %0d", i, lat, lat_model(8, int'(mag))); end
      end
   endtask

   task automatic test_stall();
      int  n;
      bit  seen;
      @(negedge clk);
      u8_a = 8'd25; u8_b = 8'd4; u8_in_valid = 1'b1; u8_out_ready = 1'b0;
      @(posedge clk);
      #1 u8_in_valid = 1'b0;
      n = 0;
      while (!u8_out_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      checks++;
      if (u8_out_valid !== 1'b1) begin errors++; $display("FAIL stall_timeout got out_valid=%b want 1", u8_out_valid); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         u8_a = ~u8_a; u8_b = ~u8_b; u8_in_valid = ~u8_in_valid;
         @(posedge clk);
         #1;
         checks++;
         if (u8_p !== 16'd100) begin errors++; $display("FAIL stall_p cyc%0d got %0d want 100", c, u8_p); end
         checks++;
         if (u8_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc%0d got %b want 0", c, u8_in_ready); end
         checks++;
         if (u8_out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc%0d got %b want 1", c, u8_out_valid); end
      end
      @(negedge clk);
      u8_in_valid = 1'b0; u8_out_ready = 1'b1;
      @(posedge clk);
      #1 u8_out_ready = 1'b0;
      checks++;
      if (u8_out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_out_valid got %b want 0", u8_out_valid); end
      checks++;
      if (u8_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_in_ready got %b want 1", u8_in_ready); end
      checks++;
      if (u8_p !== 16'd100) begin errors++; $display("FAIL stall_hold_p got %0d want 100", u8_p); end
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1 seen |= u8_out_valid;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL stall_single_handshake got extra out_valid=%b want 0", seen); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int lat;
      logic [15:0] p;
      bit ok;
      seen = 1'b0;
      @(negedge clk);
      u8_a = 8'd9; u8_b = 8'd9; u8_in_valid = 1'b1; u8_out_ready = 1'b1;
      @(posedge clk);
      #1 u8_in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1 seen |= u8_out_valid;
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (u8_in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", u8_in_ready); end
      checks++;
      if (u8_p !== 16'd0) begin errors++; $display("FAIL midrst_p got %0d want 0", u8_p); end
      seen |= u8_out_valid;
      @(negedge clk);
      rst = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1 seen |= u8_out_valid;
      end
      u8_out_ready = 1'b0;
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", seen); end
      drive_op(1, 8'd7, 8'd6, lat, p, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midrst_next_timeout got no out_valid want out_valid"); end
      checks++;
      if (p !== 16'd42) begin errors++; $display("FAIL midrst_next_p got %0d want 42", p); end
   endtask

   task automatic test_early_term();
      logic [7:0]  va[3] = '{8'd77, 8'd77, 8'd3};
      logic [7:0]  vb[3] = '{8'h00, 8'h01, 8'h80};
      logic [15:0] ve[3] = '{16'd0, 16'd77, 16'd384};
`ifdef SEQ_MULT_EARLY_TERM_EN
      int          vl[3] = '{1, 1, 8};
`else
      int          vl[3] = '{8, 8, 8};
`endif
      int lat;
      logic [15:0] p;
      bit ok;
      for (int i = 0; i < 3; i++) begin
         drive_op(1, va[i], vb[i], lat, p, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL et_timeout vec%0d got no out_valid want out_valid", i); end
         checks++;
         if (p !== ve[i]) begin errors++; $display("FAIL et_product vec%0d got %0d want %0d", i, p, ve[i]); end
         checks++;
         if (lat != vl[i]) begin errors++; $display("FAIL et_latency vec%0d got %0d want %0d", i, lat, vl[i]); end
      end
   endtask

   // Test sequence and report
   initial begin
      test_reset();
      test_w2_all();
      test_u8();
      test_s8();
      test_stall();
      test_reset_mid();
      test_early_term();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits (legal 2..32).
REQ-002 The block SHALL have parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port A, input, WIDTH bits, the multiplicand.
REQ-006 The block SHALL have port B, input, WIDTH bits, the multiplier.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning A/B carry a request.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning a request can be accepted this cycle.
REQ-009 The block SHALL have port P, output, 2*WIDTH bits, the product.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning P holds a finished product.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes P this cycle.

Function
REQ-012 The FSM SHALL have three states, IDLE, BUSY and DONE, and no others.
REQ-013 in_ready SHALL be 1 exactly when the state is IDLE, and out_valid SHALL be 1 exactly when the state is DONE.
REQ-014 An accept SHALL occur on an edge where in_valid and in_ready are both 1; it captures A and B and moves IDLE to BUSY.
REQ-015 Changes on A, B or in_valid outside an accept edge SHALL have no effect on the operation in progress.
REQ-016 BUSY SHALL perform one radix-2 shift-add iteration per cycle, using an internal iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-017 The iteration that completes the product SHALL move BUSY to DONE, so that out_valid rises exactly WIDTH edges after the accept edge (subject to REQ-027).
REQ-018 With SIGNED=0, P SHALL equal A*B, zero-extended to 2*WIDTH bits.
REQ-019 With SIGNED=1, P SHALL equal the two's-complement product in 2*WIDTH bits, including the case most-negative times most-negative.
REQ-020 P SHALL stay stable while out_valid is 1 and out_ready is 0, and no request SHALL be accepted during that time.
REQ-021 An edge with out_valid and out_ready both 1 SHALL move DONE to IDLE, with in_ready rising on the following cycle; there is no overlap of a new accept with the DONE state.
REQ-022 P SHALL hold its last value in IDLE and BUSY.

Reset
REQ-023 While rst is 1 at an edge, the next state SHALL be IDLE with in_ready=1, out_valid=0, P=0, and counter and internal registers cleared.
REQ-024 Reset asserted in BUSY or DONE SHALL abandon the operation; the partial or unconsumed product is discarded and no out_valid pulse occurs for it.
REQ-025 rst SHALL take priority over an accept or an out_ready handshake on the same edge.

Configuration
REQ-026 The macro SEQ_MULT_EARLY_TERM_EN SHALL select the early-termination feature.
REQ-027 With SEQ_MULT_EARLY_TERM_EN defined, BUSY SHALL end on the first iteration after which the remaining unprocessed multiplier bits (magnitude when SIGNED=1) are all zero; latency = max(1, position of the highest set bit + 1) edges, and results SHALL be identical to the fixed-latency mode.
REQ-028 With SEQ_MULT_EARLY_TERM_EN undefined, latency SHALL be fixed at WIDTH edges for every operand value.

Verification
REQ-029 The bench SHALL cover this case: WIDTH=2, SIGNED=0, all 16 A/B pairs, out_ready=1 -> P matches A*B each time (e.g. 3*3=9, 2*3=6, 2*1=2), with fixed latency 2.
REQ-030 The bench SHALL cover this case: WIDTH=8, SIGNED=0, A=255, B=255 -> P=65025, with out_valid rising exactly 8 edges after the accept.
REQ-031 The bench SHALL cover this case: WIDTH=8, SIGNED=1, A=-3, B=5 -> P=16'hFFF1; A=-128, B=-128 -> P=16384.
REQ-032 The bench SHALL cover this case: out_ready held 0 for 5 cycles after out_valid, with A, B and in_valid toggled meanwhile -> P is unchanged, in_ready=0, and one handshake occurs when out_ready=1.
REQ-033 The bench SHALL cover this case: rst pulsed 3 cycles after an accept -> out_valid never asserts for that request, in_ready=1 and P=0 after reset, and the next request A=7, B=6 -> P=42.
REQ-034 The bench SHALL cover this case: SEQ_MULT_EARLY_TERM_EN defined, WIDTH=8 -> B=0 gives latency 1 with P=0, B=1 gives latency 1, B=8'h80 gives latency 8, each with a correct P.
